// File: rtl/cib_loopback_pattern_gen_if.sv
// Loopback pattern generator bus: test control, pattern out/return, results.
// master drives control and the returned pattern; slave is the generator.
interface cib_loopback_pattern_gen_if #(
    parameter int CHANNELS = 2,
    parameter int LFSR_W   = 16,
    parameter int CNT_W    = 16
) ();
    logic                start;
    logic [1:0]          mode;
    logic [LFSR_W-1:0]   seed;
    logic [CNT_W-1:0]    run_len;
    logic [CHANNELS-1:0] q_out;
    logic [CHANNELS-1:0] q_ret;
    logic                busy;
    logic                done;
    logic                pass;
    logic [CNT_W-1:0]    err_count;
    logic [CHANNELS-1:0] err_mask;

    modport master (
        output start, mode, seed, run_len, q_ret,
        input  q_out, busy, done, pass, err_count, err_mask
    );

    modport slave (
        input  start, mode, seed, run_len, q_ret,
        output q_out, busy, done, pass, err_count, err_mask
    );
endinterface

// File: rtl/cib_loopback_pattern_gen.sv
// Registered pattern source for routed Q->A loops, with a LAT-deep
// expected-value delay line and per-channel mismatch accounting.
module cib_loopback_pattern_gen #(
    parameter int                CHANNELS = 2,
    parameter int                LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] POLY     = 16'hB400,
    parameter int                LAT      = 1,
    parameter int                CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    cib_loopback_pattern_gen_if.slave    lb
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] M_HOLD   = 2'd0;
    localparam logic [1:0] M_TOGGLE = 2'd1;
    localparam logic [1:0] M_WALK   = 2'd2;
    localparam logic [1:0] M_LFSR   = 2'd3;
    localparam int         PC_W     = (LAT > 1) ? $clog2(LAT) : 1;

    state_t              r_state;
    state_t              w_nxt;
    logic [1:0]          r_mode;
    logic [CNT_W-1:0]    r_rl;
    logic [CNT_W-1:0]    r_cnt;
    logic [PC_W-1:0]     r_pcnt;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [CHANNELS-1:0] r_q;
    logic [CHANNELS-1:0] r_dly [LAT];
    logic [CNT_W-1:0]    r_err_cnt;
    logic [CHANNELS-1:0] r_err_mask;
    logic                r_pass;

    logic                  w_accept;
    logic                  w_busy;
    logic [LFSR_W-1:0]     w_seed_l;
    logic [LFSR_W-1:0]     w_lfsr_adv;
    logic [2*CHANNELS-1:0] w_dbl;
    logic [CHANNELS-1:0]   w_init;
    logic [CHANNELS-1:0]   w_q_adv;
    logic [CHANNELS-1:0]   w_mm;
    logic                  w_cmp;
    logic [CNT_W-1:0]      w_err_nxt;
    logic [CHANNELS-1:0]   w_mask_nxt;

    assign w_busy     = (r_state == S_PRIME) || (r_state == S_RUN);
    assign w_accept   = lb.start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_seed_l   = (lb.seed == '0) ? LFSR_W'(1) : lb.seed;
    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
    assign w_dbl      = {r_q, r_q};
    assign w_mm       = lb.q_ret ^ r_dly[LAT-1];
    assign w_cmp      = (r_state == S_RUN);
    assign w_err_nxt  = r_err_cnt + CNT_W'(w_cmp && (|w_mm));
    assign w_mask_nxt = w_cmp ? (r_err_mask | w_mm) : r_err_mask;

    // Next state: PRIME covers the loop latency, RUN covers run_len compares.
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (lb.start) w_nxt = S_PRIME;
            end
            S_PRIME: begin
                if (r_pcnt == PC_W'(LAT - 1))
                    w_nxt = (r_rl == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (r_cnt == r_rl - CNT_W'(1)) w_nxt = S_DONE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Pattern selection: first value on start and per-cycle advance.
    always_comb begin
        w_init  = lb.seed[CHANNELS-1:0];
        w_q_adv = r_q;
        unique case (lb.mode)
            M_WALK:  w_init = CHANNELS'(1);
            M_LFSR:  w_init = w_seed_l[CHANNELS-1:0];
            default: w_init = lb.seed[CHANNELS-1:0];
        endcase
        unique case (r_mode)
            M_HOLD:   w_q_adv = r_q;
            M_TOGGLE: w_q_adv = ~r_q;
            M_WALK:   w_q_adv = w_dbl[2*CHANNELS-2 -: CHANNELS];
            M_LFSR:   w_q_adv = w_lfsr_adv[CHANNELS-1:0];
            default:  w_q_adv = r_q;
        endcase
    end

    // State, pattern, delay line and error accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= M_HOLD;
            r_rl       <= '0;
            r_cnt      <= '0;
            r_pcnt     <= '0;
            r_lfsr     <= '0;
            r_q        <= '0;
            r_err_cnt  <= '0;
            r_err_mask <= '0;
            r_pass     <= 1'b0;
            for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
        end else begin
            r_state  <= w_nxt;
            r_dly[0] <= r_q;
            for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
            if (w_accept) begin
                r_mode     <= lb.mode;
                r_rl       <= lb.run_len;
                r_cnt      <= '0;
                r_pcnt     <= '0;
                r_lfsr     <= w_seed_l;
                r_q        <= w_init;
                r_err_cnt  <= '0;
                r_err_mask <= '0;
                r_pass     <= 1'b0;
            end else if (w_busy) begin
                r_q        <= w_q_adv;
                r_err_cnt  <= w_err_nxt;
                r_err_mask <= w_mask_nxt;
                if (r_mode == M_LFSR) r_lfsr <= w_lfsr_adv;
                if (r_state == S_PRIME) r_pcnt <= r_pcnt + PC_W'(1);
                if (r_state == S_RUN) r_cnt <= r_cnt + CNT_W'(1);
                if (w_nxt == S_DONE) r_pass <= (w_err_nxt == '0);
            end
        end
    end

    assign lb.q_out     = r_q;
    assign lb.busy      = w_busy;
    assign lb.done      = (r_state == S_DONE);
    assign lb.pass      = r_pass;
    assign lb.err_count = r_err_cnt;
    assign lb.err_mask  = r_err_mask;
endmodule
